// File: rtl/regfile_scoreboard_if.sv
// Bundles the writeback, read, issue and flush signals of the register file
// scoreboard. The master side is the pipeline (decode/writeback) and the
// slave side is the register file itself.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  // Writeback port
  logic                     wen;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_data;

  // Read ports, packed side by side (port k at [k*W +: W])
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  // Decode issue and pipeline squash
  logic                     iss_vld;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  // Number of registers with an outstanding producer
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output wen, w_addr, w_data, rd_addr, iss_vld, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  wen, w_addr, w_data, rd_addr, iss_vld, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with same-cycle write-to-read bypass, a
// per-register pending-write (busy) scoreboard, a flush path that squashes
// all pending producers, and an incrementally maintained busy count.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  // Register storage. Kept in flops because every entry must clear on the
  // asynchronous reset.
  logic [DATA_W-1:0] regs_reg [NREG];

  // Scoreboard state
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_W:0]   busy_cnt_reg;
  logic [ADDR_W:0]   busy_cnt_next;

  // Qualified write/issue strobes: register 0 is hard-wired when ZERO_REG=1,
  // and a flush swallows any issue in the same cycle.
  logic w_ok;
  logic iss_ok;
  logic set_new;
  logic clr_old;

  assign w_ok   = bus.wen &&
                  !((ZERO_REG != 0) && (bus.w_addr == '0));
  assign iss_ok = bus.iss_vld && !bus.flush &&
                  !((ZERO_REG != 0) && (bus.iss_addr == '0));

  // Register array update from the writeback port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (w_ok) begin
      regs_reg[bus.w_addr] <= bus.w_data;
    end
  end

  // Per-register busy next state: flush, then issue (set), then writeback
  // (clear), else hold. Set beats clear because a newer producer supersedes
  // the one completing now.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] =
          bus.flush                             ? 1'b0 :
          (iss_ok && (bus.iss_addr == IDX))     ? 1'b1 :
          (bus.wen && (bus.w_addr == IDX))      ? 1'b0 :
                                                  busy_reg[gi];
      end
    end
  endgenerate

  // At most one bit can rise (the issue target) and one can fall (the
  // writeback target) per cycle, so the count moves by -1, 0 or +1.
  assign set_new = iss_ok && !busy_reg[bus.iss_addr];
  assign clr_old = bus.wen && busy_reg[bus.w_addr] &&
                   !(iss_ok && (bus.iss_addr == bus.w_addr));

  // Next busy count: cleared by flush, otherwise adjusted by transitions
  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (bus.flush) begin
      busy_cnt_next = '0;
    end else begin
      if (set_new) begin
        busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(1);
      end
      if (clr_old) begin
        busy_cnt_next = busy_cnt_next - (ADDR_W + 1)'(1);
      end
    end
  end

  // Scoreboard and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign bus.busy_cnt = busy_cnt_reg;

  // Combinational read ports. A write landing this cycle is forwarded and
  // its producer is no longer reported busy, so the consumer need not stall.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              zero_hit;
      logic              byp_hit;

      assign ra       = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign zero_hit = (ZERO_REG != 0) && (ra == '0);
      assign byp_hit  = bus.wen && (bus.w_addr == ra);

      assign bus.rd_data[gi*DATA_W +: DATA_W] =
        (rst || zero_hit) ? '0 :
        byp_hit           ? bus.w_data :
                            regs_reg[ra];

      assign bus.rd_busy[gi] = !rst && !zero_hit && busy_reg[ra] && !byp_hit;
    end
  endgenerate

endmodule
